keyboard: RTL
=============

# keyboard

Converts the PS/2 keyboard stream from the SPI user I/O block into the EG2000's 8×8 memory-mapped keyboard matrix and feeds it into the glue logic. It deserializes PS/2 frames, tracks make/break/extended prefixes, and holds one bit per matrix key. The Z80 keyboard read path indexes the matrix by address lines: each cleared address bit selects one row. It also supplies a host-side reset request.

## Interface
- `FILTER`, default 8: number of consecutive equal samples needed to accept a new PS/2 clock level.
- `TIMEOUT`, default 35468: idle `clock` cycles (1 ms at 35.468 MHz) after which a partial frame is discarded.
- `clock`, input, 1: system clock, 35.468 MHz.
- `power`, input, 1: reset, asynchronous, active-low.
- `ps2`, input, 2: `ps2[0]` is the PS/2 clock and `ps2[1]` is the PS/2 data; both are asynchronous.
- `addr`, input, 8: Z80 A7..A0 during a keyboard read. A low bit `r` selects row `r`.
- `keyQ`, output, 8: column bits, active-high when a key is pressed. Each bit is the OR over all selected rows.
- `resetKey`, output, 1: high while F12 is held.

## Operation
- **Sync and filter:** `ps2` passes through a 2-FF synchronizer, then a FILTER-deep shift register. The filtered clock changes only when all FILTER samples agree. A filtered 1→0 transition is a bit edge, and the data bit is sampled on that cycle.
- **Framing:** an 11-bit frame is start(0), D0..D7 LSB first, parity, stop(1). A bit counter runs 0..10.
  - On the bit-10 edge the frame is valid when start=0 and stop=1, plus the parity check described under Configuration.
  - A valid frame pulses an internal `code` strobe. The counter always returns to 0.
- **Timeout:** with counter≠0 and TIMEOUT cycles since the last bit edge, the counter resets to 0 and the partial frame is dropped.
- **Decoder FSM:**
  - States: IDLE, EXT (E0 seen), REL (F0 seen), EXTREL (E0 then F0), SKIP.
  - E0 moves IDLE→EXT.
  - F0 moves IDLE→REL and EXT→EXTREL. F0 arriving in REL is absorbed.
  - E1 enters SKIP with a count of 7, so the next 7 bytes are ignored and the FSM then returns to IDLE.
  - Any other byte is applied as press (IDLE/EXT) or release (REL/EXTREL), and the FSM returns to IDLE.
  - Unmapped codes, including AA and FA, change nothing and return the FSM to IDLE.
- **Matrix, 64 registers:**
  - Row0 holds @ A..G; row1 H..O; row2 P..W; row3 X Y Z; row4 0..7; row5 8 9 : ; , - . /.
  - Row6 holds ENTER(5A) CLEAR(E0 6C, Home) BREAK(76, Esc) UP(E0 75) DOWN(E0 72) LEFT(E0 6B) RIGHT(E0 74) SPACE(29), as bits 0..7.
  - Row7 bit0 is SHIFT and bit4 is CTRL(14).
  - Examples: A=1C→row0 bit1; @ is 54.
  - Left shift (12) and right shift (59) have separate latches; row7 bit0 is their OR.
  - Non-extended 75/72/6B/74/6C (keypad) are unmapped.
  - A press of an already-pressed key and a release of an unpressed key leave the matrix unchanged.
- **F12 (07):** press sets `resetKey`, release clears it. F12 has no matrix bit.
- **Read path:** `keyQ[c]` = OR over r with `addr[r]`=0 of `matrix[r][c]`. This path is combinational. With `addr`=FF, `keyQ`=00.

## Timing
- **Reset:** while `power`=0, the matrix, both shift latches, `resetKey`, the counter, the FSM (IDLE) and the timeout counter are all cleared immediately. `keyQ`=00 for any `addr`.
- **Reset mid-frame:** the partial frame is lost. Edges of the frame's remainder are realigned by the timeout.
- **Filter latency:** a PS/2 clock fall is detected FILTER+2 cycles after the pin falls. Pulses shorter than FILTER cycles are rejected.
- **Frame-to-matrix latency:** let E be the bit-10 edge cycle. The `code` strobe is high in E+1, and the matrix and `resetKey` change at the clock ending E+1, so they are visible in E+2.
- **Read latency:** a change on `addr` appears on `keyQ` in the same cycle.
- **Update vs read:** a matrix update and a read in the same cycle give the old value before the edge and the new value after it. There is no hazard.

## Configuration
- `KEY_PARITY_EN` defined: odd parity over D0..D7+parity is required. A frame with bad parity is discarded, with no strobe and no FSM change.
- `KEY_PARITY_EN` undefined: the parity bit is sampled and ignored, and framing checks start/stop only.

## Test plan
- **Press and release:** send frame 1C, then drive `addr`=FE → `keyQ`=02. Send F0,1C → `keyQ`=00. Drive `addr`=00 with A held → `keyQ`=02.
- **Extended vs keypad:** send E0,75 → `addr`=BF gives `keyQ`=08. Send plain 75 → unchanged. Send E0,F0,75 → `keyQ`=00.
- **Parity:** send 1C with its parity bit inverted. With `KEY_PARITY_EN`: `keyQ`@FE stays 00. Without it: 02.
- **Timeout recovery:** send 5 bits, idle TIMEOUT+10 cycles, then send 5A → `addr`=BF gives `keyQ`=01. Separately, a 3-cycle PS/2 clock glitch with FILTER=8 produces no bit.
- **Dual shift:** send 12, then 59, then F0,12 → row7 bit0 is still 1 at `addr`=7F. Send F0,59 → 0. Send 07 → `resetKey`=1, and F0,07 → 0.
- **Reset:** with A held and mid-frame, pulse `power` low → `keyQ`=00 and `resetKey`=0 asynchronously. After release, a fresh 1C frame is decoded correctly (via timeout if misaligned).

Source files
------------

// File: rtl/keyboard.sv
// PS/2 keyboard to EG2000 8x8 keyboard matrix, with F12 host reset request.
// Optional build macro: KEY_PARITY_EN (enforce odd parity on received frames).
module keyboard #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 35468
) (
    input  logic       clock,
    input  logic       power,
    input  logic [1:0] ps2,
    input  logic [7:0] addr,
    output logic [7:0] keyQ,
    output logic       resetKey
);

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EXT    = 3'd1;
    localparam logic [2:0] ST_REL    = 3'd2;
    localparam logic [2:0] ST_EXTREL = 3'd3;
    localparam logic [2:0] ST_SKIP   = 3'd4;

    logic [1:0]        r_sync1, r_sync2;
    logic [FILTER-1:0] r_filt;
    logic              r_fclk;
    logic [3:0]        r_bitcnt;
    logic [8:0]        r_frame;
    logic [TW-1:0]     r_tocnt;
    logic              r_code_stb;
    logic [7:0]        r_code;
    logic [2:0]        r_state;
    logic [2:0]        r_skip;
    logic [63:0]       r_matrix;
    logic              r_lshift, r_rshift, r_reset_key;
`ifdef KEY_PARITY_EN
    logic              r_parity;
`endif

    logic              w_fall, w_data, w_frame_ok;
    logic              w_ext, w_release, w_hit;
    logic [5:0]        w_idx;
    logic [7:0][7:0]   w_rows;

    assign w_fall = r_fclk & ~(|r_filt);
    assign w_data = r_sync2[1];

`ifdef KEY_PARITY_EN
    assign w_frame_ok = ~r_frame[0] & w_data & (^{r_parity, r_frame[8:1]});
`else
    assign w_frame_ok = ~r_frame[0] & w_data;
`endif

    // Both PS/2 lines idle high, so reset to 1 keeps a spurious fall from appearing.
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_filt  <= '1;
            r_fclk  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let the sync chain shift one stage per clock.
            r_sync1 <= ps2;
            r_sync2 <= r_sync1;
            r_filt  <= {r_filt[FILTER-2:0], r_sync2[0]};
            if (&r_filt)
                r_fclk <= 1'b1;
            else if (~|r_filt)
                r_fclk <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_bitcnt   <= '0;
            r_frame    <= '0;
            r_tocnt    <= '0;
            r_code_stb <= 1'b0;
            r_code     <= '0;
`ifdef KEY_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_code_stb <= 1'b0;
            if (w_fall) begin
                r_tocnt <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    if (w_frame_ok) begin
                        r_code_stb <= 1'b1;
                        r_code     <= r_frame[8:1];
                    end
                end else begin
                    if (r_bitcnt < 4'd9)
                        r_frame[r_bitcnt] <= w_data;
`ifdef KEY_PARITY_EN
                    else
                        r_parity <= w_data;
`endif
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                // A stalled partial frame is dropped so the next start bit realigns.
                if (r_tocnt == TW'(TIMEOUT - 1)) begin
                    r_bitcnt <= '0;
                    r_tocnt  <= '0;
                end else begin
                    r_tocnt <= r_tocnt + 1'b1;
                end
            end
        end
    end

    assign w_ext     = (r_state == ST_EXT) || (r_state == ST_EXTREL);
    assign w_release = (r_state == ST_REL) || (r_state == ST_EXTREL);

    // Scan code to matrix position (row*8 + column); ext selects the E0 page.
    always_comb begin
        w_hit = 1'b1;
        w_idx = '0;
        case ({w_ext, r_code})
            9'h054: w_idx = 6'd0;   9'h01C: w_idx = 6'd1;   9'h032: w_idx = 6'd2;   9'h021: w_idx = 6'd3;
            9'h023: w_idx = 6'd4;   9'h024: w_idx = 6'd5;   9'h02B: w_idx = 6'd6;   9'h034: w_idx = 6'd7;
            9'h033: w_idx = 6'd8;   9'h043: w_idx = 6'd9;   9'h03B: w_idx = 6'd10;  9'h042: w_idx = 6'd11;
            9'h04B: w_idx = 6'd12;  9'h03A: w_idx = 6'd13;  9'h031: w_idx = 6'd14;  9'h044: w_idx = 6'd15;
            9'h04D: w_idx = 6'd16;  9'h015: w_idx = 6'd17;  9'h02D: w_idx = 6'd18;  9'h01B: w_idx = 6'd19;
            9'h02C: w_idx = 6'd20;  9'h03C: w_idx = 6'd21;  9'h02A: w_idx = 6'd22;  9'h01D: w_idx = 6'd23;
            9'h022: w_idx = 6'd24;  9'h035: w_idx = 6'd25;  9'h01A: w_idx = 6'd26;
            9'h045: w_idx = 6'd32;  9'h016: w_idx = 6'd33;  9'h01E: w_idx = 6'd34;  9'h026: w_idx = 6'd35;
            9'h025: w_idx = 6'd36;  9'h02E: w_idx = 6'd37;  9'h036: w_idx = 6'd38;  9'h03D: w_idx = 6'd39;
            9'h03E: w_idx = 6'd40;  9'h046: w_idx = 6'd41;  9'h052: w_idx = 6'd42;  9'h04C: w_idx = 6'd43;
            9'h041: w_idx = 6'd44;  9'h04E: w_idx = 6'd45;  9'h049: w_idx = 6'd46;  9'h04A: w_idx = 6'd47;
            9'h05A: w_idx = 6'd48;  9'h16C: w_idx = 6'd49;  9'h076: w_idx = 6'd50;  9'h175: w_idx = 6'd51;
            9'h172: w_idx = 6'd52;  9'h16B: w_idx = 6'd53;  9'h174: w_idx = 6'd54;  9'h029: w_idx = 6'd55;
            9'h014: w_idx = 6'd60;
            default: w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            r_state     <= ST_IDLE;
            r_skip      <= '0;
            // NOTE: the matrix is plain flops rather than RAM, so the async reset clears every key.
            r_matrix    <= '0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_reset_key <= 1'b0;
        end else if (r_code_stb) begin
            if (r_state == ST_SKIP) begin
                r_skip <= r_skip - 3'd1;
                if (r_skip == 3'd1)
                    r_state <= ST_IDLE;
            end else if (r_code == 8'hE1) begin
                r_state <= ST_SKIP;
                r_skip  <= 3'd7;
            end else if (r_code == 8'hE0 && r_state == ST_IDLE) begin
                r_state <= ST_EXT;
            end else if (r_code == 8'hF0) begin
                r_state <= w_ext ? ST_EXTREL : ST_REL;
            end else begin
                r_state <= ST_IDLE;
                if (w_hit)
                    r_matrix[w_idx] <= ~w_release;
                if (!w_ext) begin
                    if (r_code == 8'h12) r_lshift    <= ~w_release;
                    if (r_code == 8'h59) r_rshift    <= ~w_release;
                    if (r_code == 8'h07) r_reset_key <= ~w_release;
                end
            end
        end
    end

    assign w_rows   = r_matrix | {7'b0, r_lshift | r_rshift, 56'b0};
    assign resetKey = r_reset_key;

    always_comb begin
        keyQ = '0;
        for (int r = 0; r < 8; r++)
            if (!addr[r])
                keyQ = keyQ | w_rows[r];
    end

endmodule
